mmstage: RTL and testbench

- Memory-access stage directly downstream of the EX/MEM pipeline latch.
- Consumes the latched EX/MEM fields and drives the data-cache request. Generates the memory-stage stall and presents load/SC results to the MEM/WB latch.
- Owns the LL/SC link register, including coherence-invalidate snooping, and the sticky halt flag.

---
 rtl/mmstage.sv | 141 ++++++++++++++
 tb/tb_mmstage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mmstage.sv
// mmstage: memory-access pipeline stage between the EX/MEM and MEM/WB latches.
// Issues data-cache requests, generates the stage stall, and returns load data,
// SC success flags or ALU results. Owns the LL/SC link register with coherence
// snooping, and the sticky halt flag.
// Ports:
//   CLK, RST               clock, async active-high reset
//   en                     MEM/WB advance enable
//   dRENi/dWENi/datomic    latched load / store / atomic qualifiers
//   halt, RegWEN, rd       latched halt, write enable, destination
//   ALUOut, store          effective address / ALU result, store data
//   dhit, dload            cache completion and load data
//   ccinv, ccsnoopaddr     snoop invalidate strobe and address
//   dREN/dWEN/daddr/dstore cache request
//   mmstall                stage waiting on the cache
//   mmdata, RegWENo, rdo   results to MEM/WB
//   halted                 sticky halt
module mmstage #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              dRENi,
    input  logic              dWENi,
    input  logic              datomic,
    input  logic              halt,
    input  logic              RegWEN,
    input  logic [REG_W-1:0]  rd,
    input  logic [WORD_W-1:0] ALUOut,
    input  logic [WORD_W-1:0] store,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    output logic              mmstall,
    output logic [WORD_W-1:0] mmdata,
    output logic              RegWENo,
    output logic [REG_W-1:0]  rdo,
    output logic              halted
);

    typedef enum logic {IDLE, HOLD} state_t;

    // Word-granular address compare: byte offset bits are ignored.
    localparam logic [WORD_W-1:0] WORD_MASK = ~WORD_W'(3);

    state_t            state, state_next;
    logic              linkvalid;
    logic [WORD_W-1:0] linkaddr;
    logic [WORD_W-1:0] holddata;

    logic link_match, snoop_hit, ll_snoop, scok, complete;
    logic is_ll, is_sc, sc_clear, store_clear;

    function automatic logic word_eq(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
        return ((a ^ b) & WORD_MASK) == '0;
    endfunction

    assign daddr   = ALUOut;
    assign dstore  = store;
    assign rdo     = rd;
    assign RegWENo = RegWEN;

    // Link qualification; a same-cycle invalidate of the link forces SC failure.
    assign link_match = word_eq(linkaddr, ALUOut);
    assign snoop_hit  = ccinv & word_eq(ccsnoopaddr, linkaddr);
    assign ll_snoop   = ccinv & word_eq(ccsnoopaddr, ALUOut);
    assign scok       = datomic & dWENi & linkvalid & link_match & ~snoop_hit;

    assign is_ll = dRENi & datomic;
    assign is_sc = dWENi & datomic;

    // A failed SC never reaches the cache, so it clears the link when presented.
    assign sc_clear    = (state == IDLE) & is_sc & ~halted & (complete | ~scok);
    assign store_clear = complete & dWEN & ~datomic & link_match;

    // Request, stall and result generation; reset drops any request at once.
    always_comb begin
        state_next = state;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        mmstall    = 1'b0;
        mmdata     = '0;
        complete   = 1'b0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    dREN     = dRENi & ~halted;
                    dWEN     = dWENi & ~halted & (~datomic | scok);
                    mmstall  = (dREN | dWEN) & ~dhit;
                    complete = (dREN | dWEN) & dhit;
                    if (dREN)
                        mmdata = dload;
                    else if (is_sc & ~halted)
                        mmdata = WORD_W'(scok);
                    else
                        mmdata = ALUOut;
                    if (complete & ~en)
                        state_next = HOLD;
                end
                HOLD: begin
                    // Access already done; present captured result until the latch advances.
                    mmdata = holddata;
                    if (en)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, hold buffer, link register and halt flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            linkvalid <= 1'b0;
            linkaddr  <= '0;
            holddata  <= '0;
            halted    <= 1'b0;
        end else begin
            state <= state_next;
            if (complete & ~en)
                holddata <= mmdata;
            if (halt & en)
                halted <= 1'b1;
            // Invalidate wins over a simultaneous LL to the same word.
            if (complete & dREN & is_ll) begin
                linkaddr  <= ALUOut;
                linkvalid <= ~ll_snoop;
            end else if (snoop_hit | sc_clear | store_clear) begin
                linkvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmstage.sv
// Directed bench for mmstage; expected values are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_mmstage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en, dRENi, dWENi, datomic, halt, RegWEN, dhit, ccinv;
    logic [4:0]  rd;
    logic [31:0] ALUOut, store, dload, ccsnoopaddr;
    logic        dREN, dWEN, mmstall, RegWENo, halted;
    logic [31:0] daddr, dstore, mmdata;
    logic [4:0]  rdo;

    int checks = 0;
    int errors = 0;
    logic [31:0] expq[$];

    mmstage #(.WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .RST(RST), .en(en), .dRENi(dRENi), .dWENi(dWENi),
        .datomic(datomic), .halt(halt), .RegWEN(RegWEN), .rd(rd),
        .ALUOut(ALUOut), .store(store), .dhit(dhit), .dload(dload),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .mmstall(mmstall), .mmdata(mmdata), .RegWENo(RegWENo), .rdo(rdo),
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic push(input logic [31:0] v);
        expq.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = expq.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic idle_inputs();
        en = 1'b1; dRENi = 1'b0; dWENi = 1'b0; datomic = 1'b0; halt = 1'b0;
        RegWEN = 1'b0; rd = 5'd0; ALUOut = 32'h0; store = 32'h0;
        dhit = 1'b0; dload = 32'h0; ccinv = 1'b0; ccsnoopaddr = 32'h0;
    endtask

    // One completing atomic/plain access with en=1 and immediate hit.
    task automatic access(input logic r, input logic w, input logic a, input logic [31:0] addr);
        @(negedge CLK);
        idle_inputs();
        dRENi = r; dWENi = w; datomic = a; ALUOut = addr; dhit = 1'b1;
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        ALUOut = 32'h55;
        #1;
        push(0); check("rst_dREN", 32'(dREN));
        push(0); check("rst_dWEN", 32'(dWEN));
        push(0); check("rst_mmstall", 32'(mmstall));
        push(0); check("rst_mmdata", mmdata);
        push(0); check("rst_halted", 32'(halted));
        @(negedge CLK);
        RST = 1'b0;
        idle_inputs();

        // Load with a 3-cycle hit latency.
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            idle_inputs(); en = 1'b0; dRENi = 1'b1; ALUOut = 32'h100;
            #1;
            push(1); check("lw_wait_dREN", 32'(dREN));
            push(1); check("lw_wait_stall", 32'(mmstall));
            push(32'h100); check("lw_daddr", daddr);
        end
        @(negedge CLK);
        dhit = 1'b1; dload = 32'hDEADBEEF; en = 1'b1;
        #1;
        push(1); check("lw_hit_dREN", 32'(dREN));
        push(0); check("lw_hit_stall", 32'(mmstall));
        push(32'hDEADBEEF); check("lw_hit_data", mmdata);
        @(negedge CLK);
        idle_inputs();
        #1;
        push(0); check("lw_after_dREN", 32'(dREN));

        // Store completing while MEM/WB is held: single write, result held.
        @(negedge CLK);
        idle_inputs(); en = 1'b0; dWENi = 1'b1; ALUOut = 32'h40; store = 32'h55;
        dhit = 1'b1; RegWEN = 1'b1; rd = 5'd3;
        #1;
        push(1); check("sw_dWEN", 32'(dWEN));
        push(0); check("sw_stall", 32'(mmstall));
        push(32'h40); check("sw_data", mmdata);
        push(32'h55); check("sw_dstore", dstore);
        push(3); check("sw_rdo", 32'(rdo));
        push(1); check("sw_RegWENo", 32'(RegWENo));
        @(negedge CLK);
        #1;
        push(0); check("hold_dWEN", 32'(dWEN));
        push(0); check("hold_stall", 32'(mmstall));
        push(32'h40); check("hold_data", mmdata);
        @(negedge CLK);
        en = 1'b1; dhit = 1'b0;
        #1;
        push(0); check("hold_en_dWEN", 32'(dWEN));
        push(32'h40); check("hold_en_data", mmdata);
        @(negedge CLK);
        idle_inputs(); ALUOut = 32'h1234;
        #1;
        push(32'h1234); check("alu_pass", mmdata);
        push(0); check("alu_stall", 32'(mmstall));
        @(negedge CLK);
        idle_inputs(); en = 1'b0; dWENi = 1'b1; ALUOut = 32'h44;
        #1;
        push(1); check("idle_again_dWEN", 32'(dWEN));
        push(1); check("idle_again_stall", 32'(mmstall));

        // LL then SC success, then repeated SC fails.
        access(1, 0, 1, 32'h200); dload = 32'h7;
        #1;
        push(7); check("ll_data", mmdata);
        access(0, 1, 1, 32'h200);
        #1;
        push(1); check("sc_ok_dWEN", 32'(dWEN));
        push(1); check("sc_ok_data", mmdata);
        access(0, 1, 1, 32'h200); dhit = 1'b0;
        #1;
        push(0); check("sc2_dWEN", 32'(dWEN));
        push(0); check("sc2_stall", 32'(mmstall));
        push(0); check("sc2_data", mmdata);

        // Same-cycle snoop to the linked word kills the SC.
        access(1, 0, 1, 32'h200);
        access(0, 1, 1, 32'h200); ccinv = 1'b1; ccsnoopaddr = 32'h202;
        #1;
        push(0); check("sc_snoop_dWEN", 32'(dWEN));
        push(0); check("sc_snoop_data", mmdata);

        // Intervening plain store to the linked word breaks the link.
        access(1, 0, 1, 32'h300);
        access(0, 1, 0, 32'h300);
        #1;
        push(32'h300); check("sw_link_data", mmdata);
        access(0, 1, 1, 32'h300);
        #1;
        push(0); check("sc_sw_dWEN", 32'(dWEN));
        push(0); check("sc_sw_data", mmdata);
        // Store to a different word keeps the link.
        access(1, 0, 1, 32'h300);
        access(0, 1, 0, 32'h304);
        access(0, 1, 1, 32'h300);
        #1;
        push(1); check("sc_sw304_dWEN", 32'(dWEN));
        push(1); check("sc_sw304_data", mmdata);

        // Invalidate coinciding with the LL itself leaves no link.
        access(1, 0, 1, 32'h400); ccinv = 1'b1; ccsnoopaddr = 32'h400;
        access(0, 1, 1, 32'h400);
        #1;
        push(0); check("ll_snoop_dWEN", 32'(dWEN));
        push(0); check("ll_snoop_data", mmdata);

        // Halt is sticky and blocks requests; reset clears it asynchronously.
        @(negedge CLK);
        idle_inputs(); halt = 1'b1;
        #1;
        push(0); check("halt_pre", 32'(halted));
        @(negedge CLK);
        idle_inputs(); dRENi = 1'b1; ALUOut = 32'h100;
        #1;
        push(1); check("halted_set", 32'(halted));
        push(0); check("halted_dREN", 32'(dREN));
        push(0); check("halted_stall", 32'(mmstall));
        #1 RST = 1'b1;
        #1;
        push(0); check("rst_halted_clr", 32'(halted));
        push(0); check("rst_halted_dREN", 32'(dREN));
        @(negedge CLK);
        RST = 1'b0; en = 1'b0;
        #1;
        push(1); check("post_rst_dREN", 32'(dREN));
        push(1); check("post_rst_stall", 32'(mmstall));
        #1 RST = 1'b1;
        #1;
        push(0); check("rst_mid_dREN", 32'(dREN));
        push(0); check("rst_mid_stall", 32'(mmstall));
        push(0); check("rst_mid_data", mmdata);
        @(negedge CLK);
        RST = 1'b0;
        idle_inputs();

        if (expq.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
